// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle doubleword load/store responder with fixed access latency
// Define DMEM_ALIGN_CHECK_EN to also flag addresses with nonzero req_addr[2:0] as errors.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_next;

  logic [3:0]    cnt;
  logic          wr_q;
  logic [63:0]   addr_q, wdata_q;
  logic [63:0]   mem [DEPTH];

  logic          accept, do_access, leave_resp;
  logic          acc_write, acc_error;
  logic [63:0]   acc_addr, acc_wdata;
  logic [60:0]   acc_index;
  logic [AW-1:0] mem_index;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    do_access  = 1'b0;
    leave_resp = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            do_access  = 1'b1;
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          leave_resp = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // With zero latency the access happens on the accepting edge, so use the live request.
  assign acc_write = (state == S_IDLE) ? req_write : wr_q;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
  assign acc_index = acc_addr[63:3];
  assign mem_index = acc_index[AW-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_error = (acc_index >= 61'(DEPTH)) || (acc_addr[2:0] != 3'b000);
`else
  logic unused_lsb;
  assign unused_lsb = ^acc_addr[2:0];
  assign acc_error  = (acc_index >= 61'(DEPTH));
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      rsp_rdata <= 64'd0;
      rsp_error <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_error <= acc_error;
        rsp_rdata <= (acc_write || acc_error) ? 64'd0 : mem[mem_index];
      end else if (leave_resp) begin
        rsp_rdata <= 64'd0;
        rsp_error <= 1'b0;
      end
    end
  end

  // Storage is deliberately outside the reset domain: contents survive RESET.
  always_ff @(posedge CLOCK) begin
    if (do_access && acc_write && !acc_error && !RESET)
      mem[mem_index] <= acc_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table, corner-case and randomized checks for dmem_responder
module tb_dmem_responder;
  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  int tests = 0;
  int fails = 0;
  logic [63:0] ref_mem [DEPTH];

  typedef struct {
    bit          w;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] rd;
    bit          er;
  } vec_t;
  vec_t vt [9];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference memory: a byte address maps to doubleword addr/8; anything past DEPTH is an error.
  function automatic void ref_access(input bit w, input logic [63:0] a, input logic [63:0] wd,
                                     output logic [63:0] rd, output logic er);
    logic [63:0] idx;
    idx = a / 8;
    er  = (idx >= 64'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % 8 != 0) er = 1'b1;
`endif
    rd = 64'd0;
    if (!er) begin
      if (w) ref_mem[int'(idx)] = wd;
      else   rd = ref_mem[int'(idx)];
    end
  endfunction

  // Starts and ends just after a falling edge with the responder expected idle.
  task automatic do_req(input bit w, input logic [63:0] a, input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic er, output int lat, output logic rdy);
    rdy       = req_ready;
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    @(negedge CLOCK);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge CLOCK);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLOCK);
      chk("hold rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold rsp_rdata", rsp_rdata, rd);
    end
    rsp_ready = 1'b1;
    @(negedge CLOCK);
  endtask

  task automatic xact(input string name, input bit w, input logic [63:0] a, input logic [63:0] wd,
                      input int hold, input logic [63:0] exp_rd, input logic exp_er);
    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        rdy;
    do_req(w, a, wd, hold, rd, er, lat, rdy);
    chk({name, " req_ready"}, 64'(rdy), 64'd1);
    chk({name, " latency"}, 64'(lat), 64'(LATENCY));
    chk({name, " rdata"}, rd, exp_rd);
    chk({name, " error"}, 64'(er), 64'(exp_er));
    chk({name, " idle after"}, {61'd0, rsp_valid, req_ready, rsp_error}, 64'b010);
    chk({name, " rdata cleared"}, rsp_rdata, 64'd0);
  endtask

  initial begin
    logic [63:0] rd, a, wd, erd;
    logic        er, eer, rdy;
    int          lat, sel;
    bit          w;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;

    vt[0] = '{1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0};
    vt[1] = '{1'b0, 64'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0};
    vt[2] = '{1'b1, 64'h400, 64'h1234, 64'd0, 1'b1};
    vt[3] = '{1'b0, 64'h400, 64'd0, 64'd0, 1'b1};
    vt[4] = '{1'b0, 64'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    vt[5] = '{1'b0, 64'h44, 64'd0, 64'd0, 1'b1};
`else
    vt[5] = '{1'b0, 64'h44, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0};
`endif
    vt[6] = '{1'b1, 64'h3F8, 64'h55, 64'd0, 1'b0};
    vt[7] = '{1'b0, 64'h3F8, 64'd0, 64'h55, 1'b0};
    vt[8] = '{1'b0, 64'h8000_0000_0000_0040, 64'd0, 64'd0, 1'b1};

    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset rsp_error", 64'(rsp_error), 64'd0);
    RESET = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("idle req_ready", 64'(req_ready), 64'd1);
    chk("idle rsp_valid", 64'(rsp_valid), 64'd0);

    // Bring storage to a known all-zero state.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 64'(i) * 8, 64'd0, 0, rd, er, lat, rdy);

    for (int i = 0; i < 9; i++) begin
      ref_access(vt[i].w, vt[i].a, vt[i].wd, erd, eer);
      xact($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].wd, i % 3, vt[i].rd, vt[i].er);
    end

    // Backpressure: response held, new requests during RESP must be ignored.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h40;
    @(negedge CLOCK);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge CLOCK); lat++; end
    chk("bp latency", 64'(lat), 64'(LATENCY));
    chk("bp rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'h1111;
      @(negedge CLOCK);
      chk("bp rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp rdata stable", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      chk("bp req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLOCK);
    chk("bp release valid", 64'(rsp_valid), 64'd0);
    chk("bp release ready", 64'(req_ready), 64'd1);
    xact("bp reload", 1'b0, 64'h40, 64'd0, 0, 64'hDEADBEEF_CAFEF00D, 1'b0);

    // Reset while the store is still waiting: it must never commit.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8; req_wdata = 64'hFF;
    @(negedge CLOCK);
    req_valid = 1'b0;
    @(negedge CLOCK);
    chk("rst wait pending", 64'(rsp_valid), 64'd0);
    RESET = 1'b1;
    #1;
    chk("rst wait req_ready", 64'(req_ready), 64'd1);
    chk("rst wait rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    xact("rst wait load", 1'b0, 64'h8, 64'd0, 0, 64'd0, 1'b0);

    // Reset while responding: the committed store survives.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'h77;
    @(negedge CLOCK);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge CLOCK); lat++; end
    chk("rst resp reached", 64'(rsp_valid), 64'd1);
    RESET = 1'b1;
    #1;
    chk("rst resp rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLOCK);
    ref_access(1'b1, 64'h10, 64'h77, erd, eer);
    xact("rst resp load", 1'b0, 64'h10, 64'd0, 0, 64'h77, 1'b0);

    for (int n = 0; n < 150; n++) begin
      w   = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 64'(DEPTH * 8) + 64'($urandom_range(0, 4095));
      else if (sel == 1) a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else if (sel == 2) a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(1, 7));
      else if (sel == 3) a = 64'(DEPTH - 1) * 8;
      else               a = 64'($urandom_range(0, 15)) * 8;
      wd = {$urandom, $urandom};
      ref_access(w, a, wd, erd, eer);
      xact($sformatf("rand%0d", n), w, a, wd, int'($urandom_range(0, 3)), erd, eer);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
